// File: rtl/copperv_mem_pkg.sv
// Shared constants and address helpers for the copperv memory responder.
package copperv_mem_pkg;

   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned words);
      return 32'((addr >> 2) & (64'(words) - 64'd1));
   endfunction

   function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned words);
      return addr < (64'(words) << 2);
   endfunction

endpackage

// File: rtl/copperv_mem_responder_if.sv
// CPU-side bus bundle: instruction read, data read and data write channels.
interface copperv_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int RESP_WIDTH = 1
);
   logic                  ir_addr_valid;
   logic                  ir_addr_ready;
   logic [ADDR_WIDTH-1:0] ir_addr;
   logic                  ir_data_valid;
   logic                  ir_data_ready;
   logic [DATA_WIDTH-1:0] ir_data;

   logic                  dr_addr_valid;
   logic                  dr_addr_ready;
   logic [ADDR_WIDTH-1:0] dr_addr;
   logic                  dr_data_valid;
   logic                  dr_data_ready;
   logic [DATA_WIDTH-1:0] dr_data;

   logic                  dw_data_addr_valid;
   logic                  dw_data_addr_ready;
   logic [DATA_WIDTH-1:0] dw_data;
   logic [ADDR_WIDTH-1:0] dw_addr;
   logic [STRB_WIDTH-1:0] dw_strobe;
   logic                  dw_resp_valid;
   logic                  dw_resp_ready;
   logic [RESP_WIDTH-1:0] dw_resp;

   modport master (
      output ir_addr_valid, ir_addr, ir_data_ready,
      input  ir_addr_ready, ir_data_valid, ir_data,
      output dr_addr_valid, dr_addr, dr_data_ready,
      input  dr_addr_ready, dr_data_valid, dr_data,
      output dw_data_addr_valid, dw_data, dw_addr, dw_strobe, dw_resp_ready,
      input  dw_data_addr_ready, dw_resp_valid, dw_resp
   );

   modport slave (
      input  ir_addr_valid, ir_addr, ir_data_ready,
      output ir_addr_ready, ir_data_valid, ir_data,
      input  dr_addr_valid, dr_addr, dr_data_ready,
      output dr_addr_ready, dr_data_valid, dr_data,
      input  dw_data_addr_valid, dw_data, dw_addr, dw_strobe, dw_resp_ready,
      output dw_data_addr_ready, dw_resp_valid, dw_resp
   );

endinterface

// File: rtl/copperv_resp_fifo.sv
// Request queue feeding a response output register; the parent maps the queue
// head to response data combinationally and it is captured at load time.
module copperv_resp_fifo #(
   parameter int PAYLOAD_WIDTH = 32,
   parameter int OUT_WIDTH     = 32,
   parameter int DEPTH         = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [PAYLOAD_WIDTH-1:0] push_data,
   input  logic                     push_gate,
   output logic [PAYLOAD_WIDTH-1:0] head_data,
   input  logic [OUT_WIDTH-1:0]     load_data,
   input  logic                     load_gate,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_data
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PAYLOAD_WIDTH-1:0] q [DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     full, empty, push, pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign push_ready = !full && !rst && push_gate;
   assign push       = push_valid && push_ready;
   // Only the queue head feeds the register, so a fresh request takes one extra cycle
   assign pop        = !empty && load_gate && (!out_valid || out_ready);
   assign head_data  = q[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (pop) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) q[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/copperv_mem_responder.sv
// Memory-side responder for the ir/dr/dw channels backed by a word-addressed array.
// Define COPPERV_MEM_RESPONDER_STALL_EN to add LFSR-driven random stalls.
module copperv_mem_responder
   import copperv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int RESP_WIDTH  = 1,
   parameter int MEM_WORDS   = 1024,
   parameter int QUEUE_DEPTH = 2
) (
   input logic clk,
   input logic rst,
   copperv_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [2:0] push_gate, load_gate;

`ifdef COPPERV_MEM_RESPONDER_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
   end

   // Bit k stalls request acceptance, bit k+3 stalls response load (k: ir, dr, dw)
   assign push_gate = ~lfsr[2:0];
   assign load_gate = ~lfsr[5:3];
`else
   assign push_gate = 3'b111;
   assign load_gate = 3'b111;
`endif

   logic [ADDR_WIDTH-1:0] ir_head, dr_head;
   logic [DATA_WIDTH-1:0] ir_word, dr_word;
   logic [IDX_W-1:0]      ir_idx, dr_idx, wr_idx;

   assign ir_idx  = IDX_W'(word_index(64'(ir_head), MEM_WORDS));
   assign dr_idx  = IDX_W'(word_index(64'(dr_head), MEM_WORDS));
   // Reads sample the array before any same-edge write lands
   assign ir_word = addr_in_range(64'(ir_head), MEM_WORDS) ? mem[ir_idx] : '0;
   assign dr_word = addr_in_range(64'(dr_head), MEM_WORDS) ? mem[dr_idx] : '0;

   copperv_resp_fifo #(
      .PAYLOAD_WIDTH(ADDR_WIDTH), .OUT_WIDTH(DATA_WIDTH), .DEPTH(QUEUE_DEPTH)
   ) u_ir (
      .clk(clk), .rst(rst),
      .push_valid(bus.ir_addr_valid), .push_ready(bus.ir_addr_ready),
      .push_data(bus.ir_addr), .push_gate(push_gate[0]),
      .head_data(ir_head), .load_data(ir_word), .load_gate(load_gate[0]),
      .out_valid(bus.ir_data_valid), .out_ready(bus.ir_data_ready), .out_data(bus.ir_data)
   );

   copperv_resp_fifo #(
      .PAYLOAD_WIDTH(ADDR_WIDTH), .OUT_WIDTH(DATA_WIDTH), .DEPTH(QUEUE_DEPTH)
   ) u_dr (
      .clk(clk), .rst(rst),
      .push_valid(bus.dr_addr_valid), .push_ready(bus.dr_addr_ready),
      .push_data(bus.dr_addr), .push_gate(push_gate[1]),
      .head_data(dr_head), .load_data(dr_word), .load_gate(load_gate[1]),
      .out_valid(bus.dr_data_valid), .out_ready(bus.dr_data_ready), .out_data(bus.dr_data)
   );

   logic                  dw_push, dw_ok;
   logic [RESP_WIDTH-1:0] dw_code, dw_head;

   assign dw_push = bus.dw_data_addr_valid && bus.dw_data_addr_ready;
   assign dw_ok   = addr_in_range(64'(bus.dw_addr), MEM_WORDS) && (bus.dw_addr[1:0] == 2'b00);
   assign dw_code = dw_ok ? RESP_WIDTH'(RESP_OK) : RESP_WIDTH'(RESP_ERR);
   assign wr_idx  = IDX_W'(word_index(64'(bus.dw_addr), MEM_WORDS));

   copperv_resp_fifo #(
      .PAYLOAD_WIDTH(RESP_WIDTH), .OUT_WIDTH(RESP_WIDTH), .DEPTH(QUEUE_DEPTH)
   ) u_dw (
      .clk(clk), .rst(rst),
      .push_valid(bus.dw_data_addr_valid), .push_ready(bus.dw_data_addr_ready),
      .push_data(dw_code), .push_gate(push_gate[2]),
      .head_data(dw_head), .load_data(dw_head), .load_gate(load_gate[2]),
      .out_valid(bus.dw_resp_valid), .out_ready(bus.dw_resp_ready), .out_data(bus.dw_resp)
   );

   // The write commits at acceptance; rejected requests never touch the array
   always_ff @(posedge clk) begin
      if (dw_push && dw_ok) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (bus.dw_strobe[i]) mem[wr_idx][i*8 +: 8] <= bus.dw_data[i*8 +: 8];
         end
      end
   end

endmodule
